// File: rtl/restoring_divider_if.sv
// restoring_divider_if
//
// Bundles the front-panel side of the restoring divider: the Run level, the
// switch operand with its two load buttons, and the result / status signals
// that feed the hex-display drivers.
//
// Signals:
//   run          - level; starts one operation when the divider is idle
//   din          - operand value from the switches
//   loadDividend - copy din into the dividend register (idle/hold only)
//   loadDivisor  - copy din into the divisor register (idle/hold only)
//   quotient     - working / quotient register
//   remainder    - low WIDTH bits of the partial remainder
//   divByZero    - last started operation had a zero divisor
//   busy         - shift/subtract sequence in progress
//   done         - result is being held
//
// Modports:
//   master - the switch/button side (drives run, din and loads)
//   slave  - the divider itself
interface restoring_divider_if #(
  parameter int WIDTH = 8
);

  logic             run;
  logic [WIDTH-1:0] din;
  logic             loadDividend;
  logic             loadDivisor;
  logic [WIDTH-1:0] quotient;
  logic [WIDTH-1:0] remainder;
  logic             divByZero;
  logic             busy;
  logic             done;

  modport master (
    output run,
    output din,
    output loadDividend,
    output loadDivisor,
    input  quotient,
    input  remainder,
    input  divByZero,
    input  busy,
    input  done
  );

  modport slave (
    input  run,
    input  din,
    input  loadDividend,
    input  loadDivisor,
    output quotient,
    output remainder,
    output divByZero,
    output busy,
    output done
  );

endinterface

// File: rtl/restoring_divider.sv
// restoring_divider
//
// Sequential unsigned divider using the restoring shift/subtract method:
// each quotient bit costs one Shift cycle and one Sub (trial subtract)
// cycle, so a WIDTH-bit divide takes 2*WIDTH cycles after Run is sampled.
// Operands are loaded from switches while idle or holding; Run starts one
// operation and the result is held until Run is released.
//
// Ports:
//   clk_i  - system clock, all state changes on the rising edge
//   rst_i  - synchronous active-high reset; clears every register and
//            returns the controller to Start
//   bus    - restoring_divider_if.slave: run, din, loadDividend,
//            loadDivisor in; quotient, remainder, divByZero, busy, done out
module restoring_divider #(
  parameter int WIDTH = 8
) (
  input logic               clk_i,
  input logic               rst_i,
  restoring_divider_if.slave bus
);

  // The bit counter only has to reach WIDTH-1.
  localparam int              CNT_W    = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

  typedef enum logic [1:0] {
    START = 2'd0,
    SHIFT = 2'd1,
    SUB   = 2'd2,
    HOLD  = 2'd3
  } state_e;

  state_e state_q, state_d;

  logic [WIDTH-1:0] dividend_q, dividend_d;
  logic [WIDTH-1:0] divisor_q, divisor_d;
  logic [WIDTH-1:0] quotient_q, quotient_d;
  logic [WIDTH:0]   remainder_q, remainder_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             divByZero_q, divByZero_d;

  logic             busyOut;
  logic             doneOut;

  logic             divisorZero;
  logic             lastBit;
  logic             loadEnable;
  logic             fits;
  logic [WIDTH:0]   divisorExt;
  logic [WIDTH:0]   trialDiff;

  // After a shift the partial remainder can reach 2*divisor-1, which needs
  // WIDTH+1 bits, so the trial subtract is done at WIDTH+1 bits against a
  // zero-extended divisor.
  assign divisorExt  = {1'b0, divisor_q};
  assign trialDiff   = remainder_q - divisorExt;
  assign fits        = (remainder_q >= divisorExt);
  assign divisorZero = (divisor_q == '0);
  assign lastBit     = (count_q == LAST_CNT);

  // Loads are only honoured while idle or holding. In the Start cycle that
  // launches an operation they are ignored so the operation uses the
  // operands that were present before the Run edge.
  assign loadEnable = (state_q == HOLD) || ((state_q == START) && !bus.run);

  // State register.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= START;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic. A zero divisor skips the shift/subtract loop and goes
  // straight to Hold; Hold only returns to Start once Run is released, so
  // holding Run high yields exactly one operation.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      START: begin
        if (bus.run) begin
          state_d = divisorZero ? HOLD : SHIFT;
        end
      end
      SHIFT: state_d = SUB;
      SUB:   state_d = lastBit ? HOLD : SHIFT;
      HOLD: begin
        if (!bus.run) begin
          state_d = START;
        end
      end
      default: state_d = START;
    endcase
  end

  // Output decode: status outputs depend on the registered state only.
  always_comb begin
    busyOut = 1'b0;
    doneOut = 1'b0;
    unique case (state_q)
      SHIFT, SUB: busyOut = 1'b1;
      HOLD:       doneOut = 1'b1;
      default: begin
        busyOut = 1'b0;
        doneOut = 1'b0;
      end
    endcase
  end

  // Datapath next-state. Operand loads are independent of the result
  // registers; the result registers only move on the launching Start edge
  // and during Shift/Sub.
  always_comb begin
    dividend_d  = dividend_q;
    divisor_d   = divisor_q;
    quotient_d  = quotient_q;
    remainder_d = remainder_q;
    count_d     = count_q;
    divByZero_d = divByZero_q;

    if (loadEnable && bus.loadDividend) begin
      dividend_d = bus.din;
    end
    if (loadEnable && bus.loadDivisor) begin
      divisor_d = bus.din;
    end

    unique case (state_q)
      START: begin
        if (bus.run) begin
          if (divisorZero) begin
            // Divide by zero reports all-ones and passes the dividend
            // through as the remainder.
            quotient_d  = '1;
            remainder_d = {1'b0, dividend_q};
            divByZero_d = 1'b1;
          end else begin
            quotient_d  = dividend_q;
            remainder_d = '0;
            count_d     = '0;
            divByZero_d = 1'b0;
          end
        end
      end
      SHIFT: begin
        // {R,Q} shifts left as one long register; the remainder is always
        // below the divisor before the shift, so its top bit is free.
        remainder_d = {remainder_q[WIDTH-1:0], quotient_q[WIDTH-1]};
        quotient_d  = {quotient_q[WIDTH-2:0], 1'b0};
      end
      SUB: begin
        if (fits) begin
          remainder_d   = trialDiff;
          quotient_d[0] = 1'b1;
        end
        if (!lastBit) begin
          count_d = count_q + 1'b1;
        end
      end
      default: begin
        quotient_d = quotient_q;
      end
    endcase
  end

  // Datapath registers with synchronous reset; a reset mid-operation wipes
  // the operands as well as any partial result.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      dividend_q  <= '0;
      divisor_q   <= '0;
      quotient_q  <= '0;
      remainder_q <= '0;
      count_q     <= '0;
      divByZero_q <= 1'b0;
    end else begin
      dividend_q  <= dividend_d;
      divisor_q   <= divisor_d;
      quotient_q  <= quotient_d;
      remainder_q <= remainder_d;
      count_q     <= count_d;
      divByZero_q <= divByZero_d;
    end
  end

  assign bus.quotient  = quotient_q;
  assign bus.remainder = remainder_q[WIDTH-1:0];
  assign bus.divByZero = divByZero_q;
  assign bus.busy      = busyOut;
  assign bus.done      = doneOut;

endmodule

// File: tb/tb_restoring_divider.sv
// tb_restoring_divider
//
// Table-driven bench for the 8-bit restoring divider plus hand-written
// sequences for loads during an operation, Run held high, reset in the
// middle of an operation and a random operand sweep.
module tb_restoring_divider;

  localparam int WIDTH = 8;

  logic clk;
  logic rst;

  int checks;
  int failures;

  restoring_divider_if #(.WIDTH(WIDTH)) bus ();

  restoring_divider #(.WIDTH(WIDTH)) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus)
  );

  // Free-running clock, 10 time units per cycle.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] dvd;
    logic [7:0] dvs;
    int         expQ;
    int         expR;
    int         expDbz;
    int         expLat;
    int         expBusy;
  } vector_t;

  vector_t vectors[9];

  // One comparison: counts it and reports a FAIL line on mismatch.
  task automatic checkOutput(input string name, input int actual, input int expected);
    checks++;
    if (actual != expected) begin
      failures++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  // Loads dividend then divisor from the switches; called and returns on a
  // falling edge with the divider idle or holding.
  task automatic applyStimulus(input logic [7:0] dvd, input logic [7:0] dvs);
    bus.din          = dvd;
    bus.loadDividend = 1'b1;
    @(negedge clk);
    bus.din          = dvs;
    bus.loadDividend = 1'b0;
    bus.loadDivisor  = 1'b1;
    @(negedge clk);
    bus.loadDivisor  = 1'b0;
  endtask

  // Raises Run and waits for Done. latency is the number of edges after the
  // Run-sampling edge at which Done is first seen (0 = right after it).
  // loadAt >= 0 pulses loadDivisor=loadVal for two cycles starting at that
  // sample; loadAt == -1 asserts it together with Run; -2 means no load.
  task automatic runOperation(input int loadAt, input logic [7:0] loadVal,
                              output int latency, output int busyCycles);
    latency    = -1;
    busyCycles = 0;
    bus.run    = 1'b1;
    if (loadAt == -1) begin
      bus.din         = loadVal;
      bus.loadDivisor = 1'b1;
    end
    @(posedge clk);
    for (int k = 0; k < 60; k++) begin
      @(negedge clk);
      if (k == loadAt) begin
        bus.din         = loadVal;
        bus.loadDivisor = 1'b1;
      end
      if (k == loadAt + 2) begin
        bus.loadDivisor = 1'b0;
      end
      if (bus.done) begin
        latency = k;
        break;
      end
      if (bus.busy) begin
        busyCycles++;
      end
    end
    bus.loadDivisor = 1'b0;
    if (latency < 0) begin
      checks++;
      failures++;
      $display("[TB] FAIL done_timeout: got no Done, expected Done within 60 cycles");
    end
  endtask

  // Drops Run and lets the divider return to Start.
  task automatic releaseRun();
    bus.run = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    int lat;
    int busyN;
    int stable;
    logic [7:0] rDvd;
    logic [7:0] rDvs;

    checks           = 0;
    failures         = 0;
    rst              = 1'b1;
    bus.run          = 1'b0;
    bus.din          = '0;
    bus.loadDividend = 1'b0;
    bus.loadDivisor  = 1'b0;

    vectors[0] = '{8'd100, 8'd7,   14,  2,   0, 16, 16};
    vectors[1] = '{8'd255, 8'd1,   255, 0,   0, 16, 16};
    vectors[2] = '{8'd255, 8'd255, 1,   0,   0, 16, 16};
    vectors[3] = '{8'd5,   8'd9,   0,   5,   0, 16, 16};
    vectors[4] = '{8'd0,   8'd3,   0,   0,   0, 16, 16};
    vectors[5] = '{8'd200, 8'd0,   255, 200, 1, 0,  0};
    vectors[6] = '{8'd200, 8'd4,   50,  0,   0, 16, 16};
    vectors[7] = '{8'd128, 8'd3,   42,  2,   0, 16, 16};
    vectors[8] = '{8'd1,   8'd255, 0,   1,   0, 16, 16};

    // Reset state.
    repeat (2) @(negedge clk);
    checkOutput("reset_quotient", int'(bus.quotient), 0);
    checkOutput("reset_remainder", int'(bus.remainder), 0);
    checkOutput("reset_divbyzero", int'(bus.divByZero), 0);
    checkOutput("reset_busy", int'(bus.busy), 0);
    checkOutput("reset_done", int'(bus.done), 0);
    rst = 1'b0;

    // Directed vector table.
    foreach (vectors[i]) begin
      applyStimulus(vectors[i].dvd, vectors[i].dvs);
      runOperation(-2, 8'd0, lat, busyN);
      checkOutput($sformatf("vec%0d_quotient", i), int'(bus.quotient), vectors[i].expQ);
      checkOutput($sformatf("vec%0d_remainder", i), int'(bus.remainder), vectors[i].expR);
      checkOutput($sformatf("vec%0d_divbyzero", i), int'(bus.divByZero), vectors[i].expDbz);
      checkOutput($sformatf("vec%0d_latency", i), lat, vectors[i].expLat);
      checkOutput($sformatf("vec%0d_busy_cycles", i), busyN, vectors[i].expBusy);
      releaseRun();
      checkOutput($sformatf("vec%0d_done_after_release", i), int'(bus.done), 0);
    end

    // Load asserted in the same cycle as Run is ignored.
    applyStimulus(8'd100, 8'd7);
    runOperation(-1, 8'd3, lat, busyN);
    checkOutput("runload_quotient", int'(bus.quotient), 14);
    checkOutput("runload_remainder", int'(bus.remainder), 2);
    releaseRun();

    // Load during Busy is ignored; rerun confirms divisor is still 7.
    runOperation(3, 8'd3, lat, busyN);
    checkOutput("busyload_quotient", int'(bus.quotient), 14);
    checkOutput("busyload_remainder", int'(bus.remainder), 2);
    releaseRun();
    runOperation(-2, 8'd0, lat, busyN);
    checkOutput("busyload_rerun_quotient", int'(bus.quotient), 14);
    checkOutput("busyload_rerun_remainder", int'(bus.remainder), 2);

    // Load in Hold takes effect but leaves the held result alone.
    bus.din         = 8'd3;
    bus.loadDivisor = 1'b1;
    @(negedge clk);
    bus.loadDivisor = 1'b0;
    @(negedge clk);
    checkOutput("holdload_quotient", int'(bus.quotient), 14);
    checkOutput("holdload_remainder", int'(bus.remainder), 2);
    checkOutput("holdload_done", int'(bus.done), 1);
    releaseRun();
    runOperation(-2, 8'd0, lat, busyN);
    checkOutput("holdload_next_quotient", int'(bus.quotient), 33);
    checkOutput("holdload_next_remainder", int'(bus.remainder), 1);
    releaseRun();

    // Run held high for 40 cycles: one operation only, result stable.
    applyStimulus(8'd100, 8'd7);
    runOperation(-2, 8'd0, lat, busyN);
    stable = 0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (bus.done && !bus.busy && bus.quotient == 8'd14 && bus.remainder == 8'd2) begin
        stable++;
      end
    end
    checkOutput("runheld_stable_cycles", stable, 40);
    releaseRun();
    runOperation(-2, 8'd0, lat, busyN);
    checkOutput("runheld_second_quotient", int'(bus.quotient), 14);
    checkOutput("runheld_second_remainder", int'(bus.remainder), 2);
    checkOutput("runheld_second_latency", lat, 16);
    releaseRun();

    // Reset during the 5th Busy cycle.
    applyStimulus(8'd100, 8'd7);
    bus.run = 1'b1;
    @(posedge clk);
    repeat (5) @(negedge clk);
    checkOutput("midreset_busy_before", int'(bus.busy), 1);
    rst     = 1'b1;
    bus.run = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    checkOutput("midreset_quotient", int'(bus.quotient), 0);
    checkOutput("midreset_remainder", int'(bus.remainder), 0);
    checkOutput("midreset_divbyzero", int'(bus.divByZero), 0);
    checkOutput("midreset_busy", int'(bus.busy), 0);
    checkOutput("midreset_done", int'(bus.done), 0);
    runOperation(-2, 8'd0, lat, busyN);
    checkOutput("postreset_divbyzero", int'(bus.divByZero), 1);
    checkOutput("postreset_quotient", int'(bus.quotient), 255);
    checkOutput("postreset_remainder", int'(bus.remainder), 0);
    checkOutput("postreset_latency", lat, 0);
    checkOutput("postreset_busy_cycles", busyN, 0);
    releaseRun();

    // Random operand sweep against integer division.
    for (int n = 0; n < 1000; n++) begin
      rDvd = 8'($urandom_range(0, 255));
      rDvs = 8'($urandom_range(0, 255));
      applyStimulus(rDvd, rDvs);
      runOperation(-2, 8'd0, lat, busyN);
      if (rDvs == 8'd0) begin
        checkOutput($sformatf("rand%0d_div0_quotient", n), int'(bus.quotient), 255);
        checkOutput($sformatf("rand%0d_div0_remainder", n), int'(bus.remainder), int'(rDvd));
      end else begin
        checkOutput($sformatf("rand%0d_quotient_%0d_%0d", n, rDvd, rDvs),
                    int'(bus.quotient), int'(rDvd) / int'(rDvs));
        checkOutput($sformatf("rand%0d_remainder_%0d_%0d", n, rDvd, rDvs),
                    int'(bus.remainder), int'(rDvd) % int'(rDvs));
      end
      releaseRun();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
